// File: rtl/move_arbiter.sv
// Tic-tac-toe move arbiter: alternates player/CPU moves, validates them, detects win/draw.
// Optional turn timeout is compiled in with `define MOVE_ARBITER_TIMEOUT_EN.
module move_arbiter #(
    parameter int START_TURN = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        new_game,
    input  logic        player_valid,
    input  logic [1:0]  player_row,
    input  logic [1:0]  player_col,
    output logic        player_ready,
    input  logic        cpu_valid,
    input  logic [1:0]  cpu_row,
    input  logic [1:0]  cpu_col,
    output logic        cpu_ready,
    output logic [17:0] board,
    output logic        turn,
    output logic [3:0]  move_count,
    output logic        illegal,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        TURN_P = 2'd0,
        TURN_C = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic   START_SIDE  = (START_TURN != 0);
    localparam state_e START_STATE = (START_TURN != 0) ? TURN_C : TURN_P;

    state_e      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [3:0]  move_count_q, move_count_d;
    logic [1:0]  winner_q, winner_d;
    logic        illegal_q, illegal_d;
    logic        turn_q, turn_d;

    logic        in_turn;
    logic        mv_valid;
    logic [1:0]  mv_row, mv_col;
    logic [3:0]  cell_idx;
    logic [1:0]  target;
    logic        in_range;
    logic        mv_fire, mv_legal, mv_bad;
    logic [1:0]  mark;
    logic        line_hit;
    logic        timeout_hit;

    function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
        logic [8:0] own;
        for (int i = 0; i < 9; i++) begin
            own[i] = (b[2*i +: 2] == m);
        end
        return (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
               (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
               (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
               (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
    endfunction

    // Handshake: a move transfers on a rising edge where valid && ready; ready is a pure
    // function of state, and the inactive side's valid/row/col are ignored entirely.
    always_comb begin
        in_turn  = (state_q == TURN_P) || (state_q == TURN_C);
        mv_valid = 1'b0;
        mv_row   = player_row;
        mv_col   = player_col;
        if (state_q == TURN_P) begin
            mv_valid = player_valid;
        end else if (state_q == TURN_C) begin
            mv_valid = cpu_valid;
            mv_row   = cpu_row;
            mv_col   = cpu_col;
        end
        in_range = (mv_row != 2'd3) && (mv_col != 2'd3);
        cell_idx = ({2'b00, mv_row} * 4'd3) + {2'b00, mv_col};
        target   = 2'b00;
        for (int i = 0; i < 9; i++) begin
            if (cell_idx == 4'(i)) begin
                target = board_q[2*i +: 2];
            end
        end
        // new_game wins over a simultaneous handshake, so the move is simply dropped
        mv_fire  = mv_valid && !new_game;
        mv_legal = mv_fire && in_range && (target == 2'b00);
        mv_bad   = mv_fire && !(in_range && (target == 2'b00));
        mark     = turn_q ? 2'b10 : 2'b01;
        line_hit = has_line(board_q, mark);
    end

`ifdef MOVE_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        timeout_hit = in_turn && !new_game && !mv_legal && (tmo_q == TW'(TIMEOUT - 1));
        if (new_game || !in_turn || mv_legal || timeout_hit) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= START_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = START_STATE;
        end else begin
            case (state_q)
                TURN_P: begin
                    if (mv_legal)         state_d = CHECK;
                    else if (timeout_hit) state_d = TURN_C;
                end
                TURN_C: begin
                    if (mv_legal)         state_d = CHECK;
                    else if (timeout_hit) state_d = TURN_P;
                end
                CHECK: begin
                    if (line_hit || (move_count_q == 4'd9)) state_d = DONE;
                    else state_d = turn_q ? TURN_P : TURN_C;
                end
                DONE:    state_d = DONE;
                default: state_d = START_STATE;
            endcase
        end
    end

    always_comb begin
        board_d      = board_q;
        move_count_d = move_count_q;
        winner_d     = winner_q;
        turn_d       = turn_q;
        illegal_d    = 1'b0;
        if (new_game) begin
            board_d      = '0;
            move_count_d = '0;
            winner_d     = 2'b00;
            turn_d       = START_SIDE;
        end else if (in_turn) begin
            if (mv_legal) begin
                for (int i = 0; i < 9; i++) begin
                    if (cell_idx == 4'(i)) begin
                        board_d[2*i +: 2] = mark;
                    end
                end
                move_count_d = move_count_q + 4'd1;
            end else begin
                if (mv_bad) begin
                    illegal_d = 1'b1;
                end
                if (timeout_hit) begin
                    illegal_d = 1'b1;
                    turn_d    = ~turn_q;
                end
            end
        end else if (state_q == CHECK) begin
            // turn_q still names the side that just moved; the mark encoding doubles as winner code
            if (line_hit) begin
                winner_d = mark;
            end else if (move_count_q == 4'd9) begin
                winner_d = 2'b11;
            end else begin
                turn_d = ~turn_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            board_q      <= '0;
            move_count_q <= '0;
            winner_q     <= 2'b00;
            illegal_q    <= 1'b0;
            turn_q       <= START_SIDE;
        end else begin
            board_q      <= board_d;
            move_count_q <= move_count_d;
            winner_q     <= winner_d;
            illegal_q    <= illegal_d;
            turn_q       <= turn_d;
        end
    end

    always_comb begin
        player_ready = (state_q == TURN_P);
        cpu_ready    = (state_q == TURN_C);
        game_over    = (state_q == DONE);
    end

    assign board      = board_q;
    assign move_count = move_count_q;
    assign winner     = winner_q;
    assign illegal    = illegal_q;
    assign turn       = turn_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_move_arbiter.sv
// Directed bench for move_arbiter: table of game moves plus hand-written corner sequences.
// The timeout sequence runs only when MOVE_ARBITER_TIMEOUT_EN is defined.
module tb_move_arbiter;

    logic        clock;
    logic        reset;
    logic        new_game;
    logic        player_valid;
    logic [1:0]  player_row, player_col;
    logic        player_ready;
    logic        cpu_valid;
    logic [1:0]  cpu_row, cpu_col;
    logic        cpu_ready;
    logic [17:0] board;
    logic        turn;
    logic [3:0]  move_count;
    logic        illegal;
    logic        game_over;
    logic [1:0]  winner;
    logic [1:0]  dbg_state;

    int vectors    = 0;
    int miscompares = 0;
    logic [17:0] exp_board;

    move_arbiter #(.START_TURN(0), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .new_game(new_game),
        .player_valid(player_valid), .player_row(player_row), .player_col(player_col),
        .player_ready(player_ready),
        .cpu_valid(cpu_valid), .cpu_row(cpu_row), .cpu_col(cpu_col), .cpu_ready(cpu_ready),
        .board(board), .turn(turn), .move_count(move_count), .illegal(illegal),
        .game_over(game_over), .winner(winner), .dbg_state(dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    typedef struct {
        logic       ng;
        logic       side;
        logic [1:0] row;
        logic [1:0] col;
        logic       exp_ill;
        logic [3:0] exp_cnt;
        logic [1:0] exp_win;
        logic       exp_turn;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ng, input logic side, input logic [1:0] r,
                                input logic [1:0] c, input logic ill, input logic [3:0] cnt,
                                input logic [1:0] win, input logic t);
        vec_t v;
        v.ng = ng; v.side = side; v.row = r; v.col = c;
        v.exp_ill = ill; v.exp_cnt = cnt; v.exp_win = win; v.exp_turn = t;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_place(input logic side, input logic [1:0] r, input logic [1:0] c);
        int idx;
        idx = int'(r) * 3 + int'(c);
        exp_board[2*idx +: 2] = side ? 2'b10 : 2'b01;
    endtask

    task automatic drive_move(input logic side, input logic [1:0] r, input logic [1:0] c);
        int n;
        n = 0;
        @(negedge clock);
        while (!(side ? cpu_ready : player_ready) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait", (n < 20), 1);
        if (side) begin
            cpu_valid = 1'b1; cpu_row = r; cpu_col = c;
        end else begin
            player_valid = 1'b1; player_row = r; player_col = c;
        end
        @(posedge clock);
        #1;
        cpu_valid = 1'b0;
        player_valid = 1'b0;
    endtask

    task automatic do_new_game();
        @(negedge clock);
        new_game = 1'b1;
        @(posedge clock);
        #1;
        new_game = 1'b0;
        exp_board = '0;
        check("ng_board", board, 0);
        check("ng_count", move_count, 0);
        check("ng_winner", winner, 0);
        check("ng_turn", turn, 0);
    endtask

    initial begin
        vec_t v;
        reset = 1'b0; new_game = 1'b0;
        player_valid = 1'b0; player_row = 2'd0; player_col = 2'd0;
        cpu_valid = 1'b0; cpu_row = 2'd0; cpu_col = 2'd0;
        exp_board = '0;

        // game 1: player wins top row on move 5
        add(0, 0, 0, 0, 0, 1, 2'b00, 1);
        add(0, 1, 1, 0, 0, 2, 2'b00, 0);
        add(0, 0, 0, 1, 0, 3, 2'b00, 1);
        add(0, 1, 1, 1, 0, 4, 2'b00, 0);
        add(0, 0, 0, 2, 0, 5, 2'b01, 0);
        // game 2: occupied cell and out-of-range moves rejected
        add(1, 0, 1, 1, 0, 1, 2'b00, 1);
        add(0, 1, 1, 1, 1, 1, 2'b00, 1);
        add(0, 1, 0, 0, 0, 2, 2'b00, 0);
        add(0, 0, 3, 0, 1, 2, 2'b00, 0);
        add(0, 0, 2, 2, 0, 3, 2'b00, 1);
        add(0, 1, 0, 3, 1, 3, 2'b00, 1);
        add(0, 1, 2, 0, 0, 4, 2'b00, 0);
        // game 3: nine moves, no line -> draw
        add(1, 0, 0, 0, 0, 1, 2'b00, 1);
        add(0, 1, 0, 1, 0, 2, 2'b00, 0);
        add(0, 0, 0, 2, 0, 3, 2'b00, 1);
        add(0, 1, 1, 1, 0, 4, 2'b00, 0);
        add(0, 0, 1, 0, 0, 5, 2'b00, 1);
        add(0, 1, 1, 2, 0, 6, 2'b00, 0);
        add(0, 0, 2, 1, 0, 7, 2'b00, 1);
        add(0, 1, 2, 0, 0, 8, 2'b00, 0);
        add(0, 0, 2, 2, 0, 9, 2'b11, 0);
        // game 4: ninth move completes bottom row -> player wins, not draw
        add(1, 0, 0, 0, 0, 1, 2'b00, 1);
        add(0, 1, 0, 1, 0, 2, 2'b00, 0);
        add(0, 0, 1, 2, 0, 3, 2'b00, 1);
        add(0, 1, 0, 2, 0, 4, 2'b00, 0);
        add(0, 0, 2, 0, 0, 5, 2'b00, 1);
        add(0, 1, 1, 0, 0, 6, 2'b00, 0);
        add(0, 0, 2, 1, 0, 7, 2'b00, 1);
        add(0, 1, 1, 1, 0, 8, 2'b00, 0);
        add(0, 0, 2, 2, 0, 9, 2'b01, 0);

        // reset state, checked while reset is held and after release
        repeat (2) @(posedge clock);
        #1;
        check("rst_board", board, 0);
        check("rst_count", move_count, 0);
        check("rst_winner", winner, 0);
        check("rst_illegal", illegal, 0);
        check("rst_game_over", game_over, 0);
        check("rst_turn", turn, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_p_ready", player_ready, 1);
        check("rst_c_ready", cpu_ready, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.ng) do_new_game();
            drive_move(v.side, v.row, v.col);
            if (!v.exp_ill) model_place(v.side, v.row, v.col);
            check($sformatf("v%0d_illegal", i), illegal, v.exp_ill);
            check($sformatf("v%0d_count", i), move_count, v.exp_cnt);
            check($sformatf("v%0d_board", i), board, exp_board);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_ill_clear", i), illegal, 0);
            check($sformatf("v%0d_winner", i), winner, v.exp_win);
            check($sformatf("v%0d_turn", i), turn, v.exp_turn);
            check($sformatf("v%0d_game_over", i), game_over, (v.exp_win != 2'b00));
            if (v.exp_win != 2'b00) begin
                check($sformatf("v%0d_readies", i), {player_ready, cpu_ready}, 2'b00);
            end
        end

        // DONE holds its results
        repeat (3) @(posedge clock);
        #1;
        check("done_hold_winner", winner, 2'b01);
        check("done_hold_count", move_count, 9);
        check("done_hold_board", board, exp_board);
        check("done_state", dbg_state, 3);

        // new_game together with a player handshake mid-game: move is discarded
        do_new_game();
        drive_move(0, 0, 0);
        drive_move(1, 1, 1);
        begin
            int n;
            n = 0;
            @(negedge clock);
            while (!player_ready && n < 20) begin
                @(negedge clock);
                n++;
            end
            check("ng_mv_ready_wait", (n < 20), 1);
        end
        new_game = 1'b1;
        player_valid = 1'b1; player_row = 2'd2; player_col = 2'd2;
        @(posedge clock);
        #1;
        new_game = 1'b0;
        player_valid = 1'b0;
        check("ng_mv_board", board, 0);
        check("ng_mv_count", move_count, 0);
        check("ng_mv_illegal", illegal, 0);
        check("ng_mv_turn", turn, 0);
        @(posedge clock);
        #1;
        check("ng_mv_board_after", board, 0);
        check("ng_mv_ready_after", player_ready, 1);

        // asynchronous reset mid-game drops all moves
        drive_move(0, 1, 1);
        check("mid_board_set", board, 18'h00100);
        #3;
        reset = 1'b0;
        #1;
        check("arst_board", board, 0);
        check("arst_count", move_count, 0);
        check("arst_turn", turn, 0);
        check("arst_game_over", game_over, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("arst_p_ready", player_ready, 1);
        check("arst_board_after", board, 0);

`ifdef MOVE_ARBITER_TIMEOUT_EN
        // player idles for TIMEOUT=4 cycles from the start of the turn
        do_new_game();
        repeat (3) @(posedge clock);
        #1;
        check("tmo_early_illegal", illegal, 0);
        check("tmo_early_turn", turn, 0);
        @(posedge clock);
        #1;
        check("tmo_illegal", illegal, 1);
        check("tmo_turn", turn, 1);
        check("tmo_board", board, 0);
        check("tmo_c_ready", cpu_ready, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
